rd_sched: RTL and testbench
===========================

Name: rd_sched

Overview:
- Packet-read scheduler in front of rd_ctrl.
- Buffers packet descriptors (control word, begin address, end address) produced by the capture/write side.
- Launches them one at a time into rd_ctrl and waits for completion before issuing the next.
- Drops degenerate descriptors without occupying rd_ctrl, supports software pause, and maintains sent/skipped counters for CSR readback.

Parameters:
- ADDR_W, 32, width of begin/end byte addresses and control word.
- DESC_DEPTH, 8, descriptor FIFO depth; power of two, >= 2.
- TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with RD_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  descriptor FIFO can accept.
- desc_ctrl  in  ADDR_W  control word for rd_ctrl.
- desc_begin  in  ADDR_W  packet start byte address.
- desc_end  in  ADDR_W  packet end byte address (exclusive).
- pause  in  1  inhibit new launches; never aborts an active transfer.
- rd_ctrl  out  1  run/enable to rd_ctrl, held high for the whole transfer.
- control  out  ADDR_W  to rd_ctrl.
- pkt_begin  out  ADDR_W  to rd_ctrl.
- pkt_end  out  ADDR_W  to rd_ctrl.
- rd_ctrl_rdy  in  1  from rd_ctrl: transfer complete.
- pkt_done  out  1  one-cycle pulse per completed packet.
- busy  out  1  high in LOAD/RUN/GAP.
- desc_level  out  $clog2(DESC_DEPTH)+1  FIFO occupancy.
- pkts_sent  out  32  completed packets; wraps.
- pkts_skipped  out  16  dropped descriptors; saturates at 0xFFFF.

Behaviour:
- Reset (async, active-high): rd_ctrl=0, pkt_done=0, busy=0, control/pkt_begin/pkt_end=0, counters=0, FIFO flushed (desc_level=0, desc_ready=1), state IDLE.
- Reset mid-transfer deasserts rd_ctrl immediately; the in-flight descriptor is lost and is not counted.
- Push: occurs on desc_valid && desc_ready.
  - desc_ready = !full; it is low whenever full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: level unchanged.
- FSM states: IDLE, LOAD, RUN, GAP.
  - IDLE: if !empty && !pause → pop head into output registers, go LOAD.
  - LOAD: if desc_end <= desc_begin (unsigned) → pkts_skipped++, go IDLE with rd_ctrl kept 0. Otherwise rd_ctrl<=1, go RUN.
  - RUN: rd_ctrl=1; control/pkt_begin/pkt_end stable. When rd_ctrl_rdy is sampled 1: rd_ctrl<=0, pkt_done<=1 for one cycle, pkts_sent++, go GAP.
  - GAP: one cycle with rd_ctrl=0 so rd_ctrl re-arms, then go IDLE.
- Latency:
  - Push into an empty FIFO at edge T0 → pop at T1 → rd_ctrl high after T2.
  - rd_ctrl falling to next rd_ctrl rising: minimum 3 cycles with back-to-back descriptors.
- Address outputs hold their last value after completion; they are zeroed only by reset.
- rd_ctrl_rdy outside RUN is ignored.
- pause asserted during RUN takes effect at the next IDLE.

Optional Feature:
- Macro: RD_SCHED_TIMEOUT_EN.
- When defined:
  - Cycle counter runs in RUN.
  - Reaching TIMEOUT_CYC without rd_ctrl_rdy → rd_ctrl<=0, go GAP, set sticky output err_timeout (1 bit), no pkt_done, pkts_sent unchanged.
  - err_timeout clears only on reset.
- When not defined: no counter, no err_timeout port; RUN waits indefinitely.

Decomposition:
- Package rd_sched_pkg: sched_state_e enum {IDLE, LOAD, RUN, GAP}; desc_t packed struct {ctrl, begin_addr, end_addr}; SKIP_CNT_MAX constant.
- Sub-module rd_sched_fifo: synchronous FIFO of desc_t with full/empty/level, DESC_DEPTH entries, async active-high reset.

Test Plan:
- Single packet: push {ctrl=0, begin=0, end=32}, rd_ctrl_rdy pulsed 9 cycles after rd_ctrl rises → rd_ctrl high 2 cycles after push, pkt_begin=0, pkt_end=32 stable throughout, one pkt_done, pkts_sent=1.
- Back-to-back: push 3 descriptors (0-32, 32-64, 64-96) → three rd_ctrl pulses in order, each separated by ≥3 low cycles, pkts_sent=3, desc_level reaches 0.
- Empty/invalid: push {begin=0, end=0} then {begin=64, end=32} → rd_ctrl never rises, pkts_skipped=2, pkts_sent=0.
- Full/backpressure: with pause=1, push 9 descriptors at DESC_DEPTH=8 → desc_ready=0 after the 8th, 9th held; release pause → all 9 sent in order.
- Pause and reset: pause=1 during RUN → current packet completes, next is not launched until pause=0. Then assert reset during RUN → rd_ctrl=0 immediately, desc_level=0, counters=0.
- RD_SCHED_TIMEOUT_EN with TIMEOUT_CYC=16: never assert rd_ctrl_rdy → rd_ctrl drops after 16 RUN cycles, err_timeout=1 sticky, next descriptor still launched.

Source files
------------

// File: rtl/rd_sched_pkg.sv
// rtl/rd_sched_pkg.sv - shared types and constants for the packet-read scheduler
`timescale 1ns/1ps
package rd_sched_pkg;

  localparam int          DESC_ADDR_W  = 32;
  localparam logic [15:0] SKIP_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] ctrl;
    logic [DESC_ADDR_W-1:0] begin_addr;
    logic [DESC_ADDR_W-1:0] end_addr;
  } desc_t;

endpackage

// File: rtl/rd_sched_if.sv
// rtl/rd_sched_if.sv - descriptor push and rd_ctrl launch signals of the scheduler
`timescale 1ns/1ps
interface rd_sched_if #(
  parameter int ADDR_W = 32
);
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_ctrl;
  logic [ADDR_W-1:0] desc_begin;
  logic [ADDR_W-1:0] desc_end;
  logic              rd_ctrl;
  logic [ADDR_W-1:0] control;
  logic [ADDR_W-1:0] pkt_begin;
  logic [ADDR_W-1:0] pkt_end;
  logic              rd_ctrl_rdy;

  modport master (
    input  desc_valid, desc_ctrl, desc_begin, desc_end, rd_ctrl_rdy,
    output desc_ready, rd_ctrl, control, pkt_begin, pkt_end
  );

  modport slave (
    output desc_valid, desc_ctrl, desc_begin, desc_end, rd_ctrl_rdy,
    input  desc_ready, rd_ctrl, control, pkt_begin, pkt_end
  );
endinterface

// File: rtl/rd_sched_fifo.sv
// rtl/rd_sched_fifo.sv - descriptor FIFO with full/empty/level; DEPTH must be a power of two
`timescale 1ns/1ps
module rd_sched_fifo
  import rd_sched_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  desc_t            i_data,
  input  logic             i_pop,
  output desc_t            o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  desc_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];
  // A push offered while full is refused even if a pop frees a slot this cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rd_sched.sv
// rtl/rd_sched.sv - launches buffered packet descriptors into rd_ctrl one at a time
// Optional RUN watchdog with sticky o_err_timeout: define RD_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module rd_sched
  import rd_sched_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DESC_DEPTH  = 8,
`ifdef RD_SCHED_TIMEOUT_EN
  parameter  int TIMEOUT_CYC = 4096,
`endif
  localparam int LVL_W       = $clog2(DESC_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  rd_sched_if.master        bus,
  input  logic              i_pause,
  output logic              o_pkt_done,
  output logic              o_busy,
  output logic [LVL_W-1:0]  o_desc_level,
  output logic [31:0]       o_pkts_sent,
`ifdef RD_SCHED_TIMEOUT_EN
  output logic [15:0]       o_pkts_skipped,
  output logic              o_err_timeout
`else
  output logic [15:0]       o_pkts_skipped
`endif
);

  sched_state_e      r_state;
  logic              r_rd_ctrl;
  logic              r_pkt_done;
  logic              r_busy;
  logic [ADDR_W-1:0] r_control;
  logic [ADDR_W-1:0] r_pkt_begin;
  logic [ADDR_W-1:0] r_pkt_end;
  logic [31:0]       r_sent;
  logic [15:0]       r_skipped;
  desc_t             w_push_desc;
  desc_t             w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

`ifdef RD_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_timeout;
  assign o_err_timeout = r_err_timeout;
`endif

  assign w_push_desc = '{ctrl:       DESC_ADDR_W'(bus.desc_ctrl),
                         begin_addr: DESC_ADDR_W'(bus.desc_begin),
                         end_addr:   DESC_ADDR_W'(bus.desc_end)};
  assign w_pop = (r_state == IDLE) && !w_empty && !i_pause;

  rd_sched_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.desc_valid),
    .i_data  (w_push_desc),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_desc_level)
  );

  assign bus.desc_ready = !w_full;
  assign bus.rd_ctrl    = r_rd_ctrl;
  assign bus.control    = r_control;
  assign bus.pkt_begin  = r_pkt_begin;
  assign bus.pkt_end    = r_pkt_end;
  assign o_pkt_done     = r_pkt_done;
  assign o_busy         = r_busy;
  assign o_pkts_sent    = r_sent;
  assign o_pkts_skipped = r_skipped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rd_ctrl     <= 1'b0;
      r_pkt_done    <= 1'b0;
      r_busy        <= 1'b0;
      r_control     <= '0;
      r_pkt_begin   <= '0;
      r_pkt_end     <= '0;
      r_sent        <= '0;
      r_skipped     <= '0;
`ifdef RD_SCHED_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_control   <= ADDR_W'(w_head.ctrl);
            r_pkt_begin <= ADDR_W'(w_head.begin_addr);
            r_pkt_end   <= ADDR_W'(w_head.end_addr);
            r_busy      <= 1'b1;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          // Empty or inverted ranges never reach rd_ctrl.
          if (r_pkt_end <= r_pkt_begin) begin
            if (r_skipped != SKIP_CNT_MAX) r_skipped <= r_skipped + 16'd1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_rd_ctrl <= 1'b1;
`ifdef RD_SCHED_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
            r_state   <= RUN;
          end
        end
        RUN: begin
          if (bus.rd_ctrl_rdy) begin
            r_rd_ctrl  <= 1'b0;
            r_pkt_done <= 1'b1;
            r_sent     <= r_sent + 32'd1;
            r_state    <= GAP;
          end
`ifdef RD_SCHED_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            r_rd_ctrl     <= 1'b0;
            r_err_timeout <= 1'b1;
            r_state       <= GAP;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end
        GAP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_sched.sv
// tb/tb_rd_sched.sv - randomized and directed bench for rd_sched against a queue-based model
`timescale 1ns/1ps
module tb_rd_sched;
  import rd_sched_pkg::*;

  localparam int AW     = 32;
  localparam int DEPTH  = 8;
  localparam int TO_CYC = 16;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pause = 1'b0;
  logic             pkt_done;
  logic             busy;
  logic [LVL_W-1:0] desc_level;
  logic [31:0]      pkts_sent;
  logic [15:0]      pkts_skipped;
`ifdef RD_SCHED_TIMEOUT_EN
  logic             err_timeout;
`endif

  rd_sched_if #(.ADDR_W(AW)) bus ();

  rd_sched #(
    .ADDR_W      (AW),
`ifdef RD_SCHED_TIMEOUT_EN
    .TIMEOUT_CYC (TO_CYC),
`endif
    .DESC_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .i_pause        (pause),
    .o_pkt_done     (pkt_done),
    .o_busy         (busy),
    .o_desc_level   (desc_level),
    .o_pkts_sent    (pkts_sent),
`ifdef RD_SCHED_TIMEOUT_EN
    .o_err_timeout  (err_timeout),
`endif
    .o_pkts_skipped (pkts_skipped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL bound_%s: wait expired before the event at %0t", name, $time);
  endtask

  // Reference model: a descriptor queue plus the one descriptor currently held by the scheduler.
  typedef struct { logic [31:0] c; logic [31:0] b; logic [31:0] e; } mdesc_t;
  mdesc_t      mq[$];
  mdesc_t      m_hd;
  logic [31:0] m_ctrl = '0, m_beg = '0, m_end = '0;
  logic [31:0] m_sent = '0;
  int          m_skip = 0;
  bit          m_loaded = 0, m_run = 0, m_gap = 0, m_done = 0, m_err = 0;
  bit          m_can_push;
  int          run_cyc = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ctrl = '0; m_beg = '0; m_end = '0;
      m_sent = '0; m_skip = 0;
      m_loaded = 0; m_run = 0; m_gap = 0; m_done = 0; m_err = 0;
    end else begin
      m_can_push = bus.desc_valid && (mq.size() < DEPTH);
      m_done = 0;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_run) begin
        if (bus.rd_ctrl_rdy) begin
          m_run = 0; m_done = 1; m_sent = m_sent + 32'd1; m_gap = 1;
        end
`ifdef RD_SCHED_TIMEOUT_EN
        else begin
          run_cyc++;
          if (run_cyc == TO_CYC) begin m_run = 0; m_gap = 1; m_err = 1; end
        end
`endif
      end else if (m_loaded) begin
        m_loaded = 0;
        if (m_end <= m_beg) begin
          if (m_skip < 65535) m_skip++;
        end else begin
          m_run = 1; run_cyc = 0;
        end
      end else if (mq.size() > 0 && !pause) begin
        m_hd = mq.pop_front();
        m_ctrl = m_hd.c; m_beg = m_hd.b; m_end = m_hd.e;
        m_loaded = 1;
      end
      if (m_can_push) mq.push_back('{c: bus.desc_ctrl, b: bus.desc_begin, e: bus.desc_end});
    end
  end

  // Per-cycle compare against the model, plus edge monitors for the directed timing checks.
  int          cyc_n = 0, push_neg = 0, rise_neg = 0, fall_neg = 0;
  int          n_rise = 0, n_fall = 0, n_done = 0;
  int          min_gap = 1000, min_gap_all = 1000;
  bit          prev_rd = 0, have_fall = 0;
  logic [31:0] rise_beg[$];

  always @(posedge clk) begin
    if (!reset && bus.desc_valid && bus.desc_ready) push_neg = cyc_n;
  end

  always @(negedge clk) begin
    cyc_n++;
    chk("rd_ctrl", bus.rd_ctrl, m_run);
    chk("desc_ready", bus.desc_ready, mq.size() < DEPTH);
    chk("desc_level", desc_level, mq.size());
    chk("control", bus.control, m_ctrl);
    chk("pkt_begin", bus.pkt_begin, m_beg);
    chk("pkt_end", bus.pkt_end, m_end);
    chk("pkt_done", pkt_done, m_done);
    chk("busy", busy, m_loaded || m_run || m_gap);
    chk("pkts_sent", pkts_sent, m_sent);
    chk("pkts_skipped", pkts_skipped, m_skip);
`ifdef RD_SCHED_TIMEOUT_EN
    chk("err_timeout", err_timeout, m_err);
`endif
    if (bus.rd_ctrl && !prev_rd) begin
      n_rise++;
      rise_neg = cyc_n;
      rise_beg.push_back(bus.pkt_begin);
      if (have_fall) begin
        if (cyc_n - fall_neg < min_gap) min_gap = cyc_n - fall_neg;
        if (cyc_n - fall_neg < min_gap_all) min_gap_all = cyc_n - fall_neg;
      end
    end
    if (!bus.rd_ctrl && prev_rd) begin
      n_fall++;
      fall_neg = cyc_n;
      have_fall = 1;
    end
    if (pkt_done) n_done++;
    prev_rd = bus.rd_ctrl;
  end

  // rd_ctrl responder: 0 never completes, 1 completes resp_dly cycles after the rise, 2 random noise.
  int rdy_mode = 0, resp_dly = 9, hi_cnt = 0;

  always @(negedge clk) begin
    case (rdy_mode)
      1: begin
        if (bus.rd_ctrl) begin
          hi_cnt++;
          bus.rd_ctrl_rdy = (hi_cnt == resp_dly);
        end else begin
          hi_cnt = 0;
          bus.rd_ctrl_rdy = 1'b0;
        end
      end
      2: begin
        hi_cnt = 0;
        bus.rd_ctrl_rdy = ($urandom_range(0, 3) == 0);
      end
      default: begin
        hi_cnt = 0;
        bus.rd_ctrl_rdy = 1'b0;
      end
    endcase
  end

  task automatic push_desc(input logic [31:0] c, input logic [31:0] b, input logic [31:0] e);
    logic rs;
    int   n = 0;
    @(negedge clk);
    bus.desc_valid = 1'b1;
    bus.desc_ctrl  = c;
    bus.desc_begin = b;
    bus.desc_end   = e;
    forever begin
      rs = bus.desc_ready;
      @(posedge clk);
      if (rs) break;
      n++;
      if (n > 2000) begin bound_fail("push"); break; end
      @(negedge clk);
    end
  endtask

  task automatic desc_idle();
    @(negedge clk);
    bus.desc_valid = 1'b0;
  endtask

  task automatic wait_rise(input int limit);
    int s = n_rise;
    int n = 0;
    while (n_rise == s) begin
      @(negedge clk); #1;
      n++;
      if (n > limit) begin bound_fail("rise"); return; end
    end
  endtask

  task automatic wait_fall(input int limit);
    int s = n_fall;
    int n = 0;
    while (n_fall == s) begin
      @(negedge clk); #1;
      n++;
      if (n > limit) begin bound_fail("fall"); return; end
    end
  endtask

  task automatic wait_done(input int limit);
    int s = n_done;
    int n = 0;
    while (n_done == s) begin
      @(negedge clk); #1;
      n++;
      if (n > limit) begin bound_fail("done"); return; end
    end
  endtask

  task automatic wait_sent(input int target, input int limit);
    int n = 0;
    while (pkts_sent != 32'(target)) begin
      @(negedge clk); #1;
      n++;
      if (n > limit) begin bound_fail("sent"); return; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int s_rise, s_done;

  initial begin
    bus.desc_valid = 1'b0;
    bus.desc_ctrl  = '0;
    bus.desc_begin = '0;
    bus.desc_end   = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_ctrl", bus.rd_ctrl, 0);
    chk("rst_desc_ready", bus.desc_ready, 1);
    chk("rst_desc_level", desc_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_end", bus.pkt_end, 0);
    chk("rst_sent", pkts_sent, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single packet: rd_ctrl rises two edges after the push edge and stays up for 9 cycles.
    rdy_mode = 1; resp_dly = 9;
    push_desc(32'h0, 32'd0, 32'd32);
    desc_idle();
    wait_sent(1, 100);
    repeat (3) @(negedge clk);
    #1;
    chk("single_latency", rise_neg - push_neg, 3);
    chk("single_high", fall_neg - rise_neg, 9);
    chk("single_done", n_done, 1);
    chk("single_sent", pkts_sent, 1);
    chk("single_end_hold", bus.pkt_end, 32);

    // Back-to-back: three packets in order with exactly three low cycles between them.
    resp_dly = 2; min_gap = 1000;
    rise_beg.delete();
    push_desc(32'h1, 32'd0, 32'd32);
    push_desc(32'h2, 32'd32, 32'd64);
    push_desc(32'h3, 32'd64, 32'd96);
    desc_idle();
    wait_sent(4, 200);
    repeat (2) @(negedge clk);
    #1;
    chk("b2b_sent", pkts_sent, 4);
    chk("b2b_level", desc_level, 0);
    chk("b2b_min_gap", min_gap, 3);
    chk("b2b_count", rise_beg.size(), 3);
    if (rise_beg.size() == 3) begin
      chk("b2b_order1", rise_beg[1], 32);
      chk("b2b_order2", rise_beg[2], 64);
    end

    // Degenerate descriptors are dropped without touching rd_ctrl.
    s_rise = n_rise;
    push_desc(32'h4, 32'd0, 32'd0);
    push_desc(32'h5, 32'd64, 32'd32);
    desc_idle();
    repeat (10) @(negedge clk);
    #1;
    chk("deg_skipped", pkts_skipped, 2);
    chk("deg_sent", pkts_sent, 4);
    chk("deg_no_rise", n_rise - s_rise, 0);

    // Full FIFO under pause: the ninth descriptor is held until pause releases.
    @(negedge clk);
    pause = 1'b1;
    rise_beg.delete();
    for (int i = 0; i < 8; i++) push_desc(32'(i), 32'(256 + i * 16), 32'(272 + i * 16));
    fork
      push_desc(32'd8, 32'd384, 32'd400);
      begin
        repeat (4) @(negedge clk);
        #1;
        chk("full_ready", bus.desc_ready, 0);
        chk("full_level", desc_level, 8);
        pause = 1'b0;
      end
    join
    desc_idle();
    wait_sent(13, 600);
    chk("full_sent", pkts_sent, 13);
    chk("full_count", rise_beg.size(), 9);
    if (rise_beg.size() == 9)
      for (int i = 0; i < 9; i++) chk("full_order", rise_beg[i], 32'(256 + i * 16));

    // Pause during RUN lets the packet finish but blocks the next launch; then reset mid-transfer.
    resp_dly = 6;
    push_desc(32'h10, 32'd512, 32'd528);
    push_desc(32'h11, 32'd528, 32'd544);
    push_desc(32'h12, 32'd544, 32'd560);
    desc_idle();
    wait_rise(50);
    pause = 1'b1;
    wait_done(50);
    repeat (8) @(negedge clk);
    #1;
    chk("pause_rd_ctrl", bus.rd_ctrl, 0);
    chk("pause_busy", busy, 0);
    chk("pause_level", desc_level, 2);
    pause = 1'b0;
    wait_rise(50);
    chk("pause_resume_beg", bus.pkt_begin, 528);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_rd_ctrl", bus.rd_ctrl, 0);
    chk("rst_mid_level", desc_level, 0);
    chk("rst_mid_sent", pkts_sent, 0);
    chk("rst_mid_skipped", pkts_skipped, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

`ifdef RD_SCHED_TIMEOUT_EN
    // Watchdog: rd_ctrl drops after TO_CYC RUN cycles and the next descriptor still launches.
    rdy_mode = 0;
    s_done = n_done;
    push_desc(32'h20, 32'h1000, 32'h1040);
    push_desc(32'h21, 32'h1100, 32'h1140);
    desc_idle();
    wait_rise(20);
    wait_fall(60);
    chk("to_high", fall_neg - rise_neg, TO_CYC);
    chk("to_err", err_timeout, 1);
    chk("to_no_done", n_done - s_done, 0);
    chk("to_sent", pkts_sent, 0);
    rdy_mode = 1; resp_dly = 3;
    wait_rise(20);
    chk("to_next_beg", bus.pkt_begin, 32'h1100);
    wait_sent(1, 50);
    chk("to_err_sticky", err_timeout, 1);
`endif

    // Random traffic: random valid, mixed good/degenerate ranges, pause toggling, noisy rd_ctrl_rdy.
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.desc_valid = ($urandom_range(0, 1) == 1);
      bus.desc_ctrl  = $urandom;
      bus.desc_begin = 32'($urandom_range(0, 32'hFFFF)) << 4;
      if ($urandom_range(0, 3) == 0)
        bus.desc_end = bus.desc_begin - 32'($urandom_range(0, 32));
      else
        bus.desc_end = bus.desc_begin + 32'($urandom_range(1, 256));
      if ($urandom_range(0, 15) == 0) pause = !pause;
    end
    @(negedge clk);
    bus.desc_valid = 1'b0;
    pause = 1'b0;
    rdy_mode = 1; resp_dly = 2;
    for (int n = 0; n <= 2000; n++) begin
      @(negedge clk); #1;
      if (desc_level == 0 && !busy) break;
      if (n == 2000) bound_fail("drain");
    end
    chk("rand_drained_level", desc_level, 0);
    chk("min_gap_overall", min_gap_all >= 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
